// File: rtl/wb_pipelined_regfile_if.sv
// Wishbone B4 pipelined-mode bus bundle for wb_pipelined_regfile.
// Signal names are from the slave's point of view.
interface wb_pipelined_regfile_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  stall_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o, stall_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o, stall_o
    );
endinterface

// File: rtl/wb_pipelined_regfile.sv
// Wishbone B4 pipelined slave register file with fixed response latency,
// outstanding-request limit, byte-lane writes and error decode.
module wb_pipelined_regfile #(
    parameter int                      ADDR_WIDTH      = 4,
    parameter int                      DATA_WIDTH      = 32,
    parameter int                      GRANULE         = 8,
    parameter int                      REGISTER_NUM    = 16,
    parameter int                      LATENCY         = 2,
    parameter int                      MAX_OUTSTANDING = 2,
    parameter logic [REGISTER_NUM-1:0] RO_MASK         = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wb_pipelined_regfile_if.slave  bus
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REGISTER_NUM);
    localparam logic [DEPTH-1:0]    RO_FULL   = DEPTH'(RO_MASK);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [DATA_WIDTH-1:0] regs_q [REGISTER_NUM];
    resp_t                 resp_q [LATENCY];
    resp_t                 resp_d [LATENCY];
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  emit, stall, accept, ack, req_err, wr_ok;
    logic [DATA_WIDTH-1:0] rd_data, lane_mask;

    // The tail stage is the response on the bus; dropping cyc_i suppresses it at once.
    assign emit   = bus.cyc_i & resp_q[LATENCY-1].valid;
    assign stall  = bus.cyc_i & (count_q == CNT_MAX) & ~emit;
    assign accept = bus.cyc_i & bus.stb_i & ~stall;
    assign ack    = emit & ~resp_q[LATENCY-1].err;

    assign bus.stall_o = stall;
    assign bus.ack_o   = ack;
    assign bus.err_o   = emit & resp_q[LATENCY-1].err;
    assign bus.dat_o   = ack ? resp_q[LATENCY-1].data : '0;

    // NOTE: every signal driven in always_comb gets a value on all paths first, so no latch is inferred.
    always_comb begin
        req_err   = ({1'b0, bus.adr_i} >= REG_LIMIT) | (bus.we_i & RO_FULL[bus.adr_i]);
        rd_data   = '0;
        lane_mask = '0;
        for (int i = 0; i < REGISTER_NUM; i++) begin
            if (bus.adr_i == ADDR_WIDTH'(i)) rd_data = regs_q[i];
        end
        for (int k = 0; k < SEL_WIDTH; k++) begin
            lane_mask[k*GRANULE +: GRANULE] = {GRANULE{bus.sel_i[k]}};
        end
    end

    assign wr_ok = accept & bus.we_i & ~req_err;

    // Read data is captured at accept, so only successful reads carry a non-zero payload.
    always_comb begin
        resp_d[0] = '{valid: accept,
                      err:   accept & req_err,
                      data:  (accept & ~bus.we_i & ~req_err) ? rd_data : '0};
        for (int i = 1; i < LATENCY; i++) begin
            resp_d[i] = resp_q[i-1];
        end
        if (!bus.cyc_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                resp_d[i] = '0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (!bus.cyc_i) begin
            count_d = '0;
        end else if (accept && !emit) begin
            count_d = count_q + CNT_W'(1);
        end else if (emit && !accept) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                resp_q[i] <= '0;
            end
            // NOTE: the register file is reset because software relies on it reading zero after reset.
            for (int i = 0; i < REGISTER_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < LATENCY; i++) begin
                resp_q[i] <= resp_d[i];
            end
            for (int i = 0; i < REGISTER_NUM; i++) begin
                if (wr_ok && bus.adr_i == ADDR_WIDTH'(i)) begin
                    regs_q[i] <= (regs_q[i] & ~lane_mask) | (bus.dat_i & lane_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_pipelined_regfile.sv
// Self-checking bench for wb_pipelined_regfile: directed scenarios plus random
// traffic compared against a queue-based model of the bus contract.
module tb_wb_pipelined_regfile;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int NREG = 12;
    localparam int LAT  = 3;
    localparam int MAXO = 2;
    localparam logic [NREG-1:0] RO = 12'h084;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_pipelined_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    wb_pipelined_regfile #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .GRANULE        (8),
        .REGISTER_NUM   (NREG),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO),
        .RO_MASK        (RO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        bit          err;
        bit          wr;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [NREG];
    int          cnum   = 0;
    int          n_vec  = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cnum, got, exp);
        end
    endtask

    // One bus cycle: drive mid-low phase, check outputs, then advance the model at the edge.
    task automatic cycle(input bit c, input bit s, input bit w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] sl, output bit acc);
        bit          emit, e_err, e_wr, exp_stall, err;
        logic [31:0] e_dat, rd;
        exp_t        e;
        @(negedge clk);
        bus.cyc_i = c;
        bus.stb_i = s;
        bus.we_i  = w;
        bus.adr_i = a;
        bus.dat_i = d;
        bus.sel_i = sl;
        #1;
        emit  = c && (q.size() > 0) && (q[0].due == cnum);
        e_err = emit ? q[0].err  : 1'b0;
        e_wr  = emit ? q[0].wr   : 1'b0;
        e_dat = (emit && !e_err && !e_wr) ? q[0].data : 32'h0;
        exp_stall = c && (q.size() == MAXO) && !emit;
        check("ack",   bus.ack_o,   emit && !e_err);
        check("err",   bus.err_o,   emit && e_err);
        check("stall", bus.stall_o, exp_stall);
        if (!(emit && !e_err && e_wr)) check("dat", bus.dat_o, e_dat);
        acc = c && s && !exp_stall;
        @(posedge clk);
        if (!c) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (acc) begin
                err = (a >= NREG) || (w && RO[a]);
                rd  = 32'h0;
                if (!err && !w) rd = mem[a];
                if (!err && w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (sl[k]) mem[a][8*k +: 8] = d[8*k +: 8];
                    end
                end
                e.due  = cnum + LAT;
                e.err  = err;
                e.wr   = w;
                e.data = rd;
                q.push_back(e);
            end
        end
        cnum++;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, acc);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] sl);
        bit acc;
        cycle(1'b1, 1'b1, 1'b1, a, d, sl, acc);
    endtask

    task automatic rd(input logic [3:0] a);
        bit acc;
        cycle(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0, acc);
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
    endtask

    initial begin
        logic [3:0] bp_adr [6];
        bit         acc;
        int         idx;

        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        bus.sel_i = '0;
        model_reset();

        // Outputs held quiet in reset, even with a request presented.
        #3;
        check("rst_ack",   bus.ack_o,   1'b0);
        check("rst_err",   bus.err_o,   1'b0);
        check("rst_dat",   bus.dat_o,   32'h0);
        check("rst_stall", bus.stall_o, 1'b0);
        bus.stb_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // Full-word write then read back.
        wr(4'd3, 32'hDEADBEEF, 4'hF);
        idle(LAT);
        rd(4'd3);
        idle(LAT + 1);

        // Byte lanes, and sel=0 write that changes nothing.
        wr(4'd5, 32'h11223344, 4'hF);
        wr(4'd5, 32'hAABBCCDD, 4'b0101);
        rd(4'd5);
        idle(LAT + 1);
        wr(4'd5, 32'h00000000, 4'h0);
        rd(4'd5);
        idle(LAT + 1);

        // Out-of-range and read-only decode errors.
        rd(4'd15);
        rd(4'd12);
        wr(4'd2, 32'hFFFFFFFF, 4'hF);
        rd(4'd2);
        wr(4'd7, 32'h12345678, 4'hF);
        rd(4'd7);
        idle(LAT + 1);

        // Back-pressure: request held until accepted, six cycles of strobe.
        wr(4'd0, 32'h0000A000, 4'hF);
        wr(4'd1, 32'h0000B001, 4'hF);
        wr(4'd4, 32'h0000C004, 4'hF);
        idle(LAT + 1);
        bp_adr = '{4'd3, 4'd5, 4'd0, 4'd1, 4'd4, 4'd6};
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 1'b0, bp_adr[idx], 32'h0, 4'h0, acc);
            if (acc) idx++;
        end
        idle(LAT + 1);

        // Abort with two reads in flight, then a fresh request.
        rd(4'd3);
        rd(4'd5);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, acc);
        rd(4'd0);
        idle(LAT + 1);

        // Abort landing exactly on the cycle a response is due.
        rd(4'd0);
        rd(4'd1);
        idle(LAT - 2);
        cycle(1'b0, 1'b1, 1'b0, 4'h3, 32'h0, 4'h0, acc);
        rd(4'd5);
        idle(LAT + 1);

        // Strobe without cycle is ignored.
        cycle(1'b0, 1'b1, 1'b1, 4'd4, 32'hFFFFFFFF, 4'hF, acc);
        rd(4'd4);
        idle(LAT + 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), acc);
        end
        idle(LAT + 1);

        // Asynchronous reset between edges while a read response is on the bus.
        wr(4'd3, 32'hCAFEF00D, 4'hF);
        idle(LAT + 1);
        rd(4'd3);
        idle(LAT - 1);
        #1;
        check("pre_rst_ack", bus.ack_o, 1'b1);
        check("pre_rst_dat", bus.dat_o, 32'hCAFEF00D);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ack", bus.ack_o, 1'b0);
        check("async_rst_err", bus.err_o, 1'b0);
        check("async_rst_dat", bus.dat_o, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        for (int a = 0; a < NREG; a++) rd(4'(a));
        idle(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
